// File: rtl/func_inverse.sv
// Inverse solver for f(a,b) = a^3 + a*b: finds the largest 8-bit a with f(a,b) <= y.
// MSB-first binary search that drives an external function unit over a start/busy handshake.
module func_inverse (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [23:0] y_bi,
    input  logic [7:0]  b_bi,
    output logic        busy_o,
    output logic [7:0]  a_bo,
    output logic        exact_o,
    output logic        err_o,
    output logic [7:0]  fn_a_bo,
    output logic [7:0]  fn_b_bo,
    output logic        fn_start_o,
    input  logic        fn_busy_i,
    input  logic [23:0] fn_result_bi
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        EVAL
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] y_q, y_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic        ex_r_q, ex_r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] res_q, res_d;
    logic [7:0]  a_q, a_d;
    logic        exact_q, exact_d;
    logic        err_q, err_d;

    logic [7:0]  cand;
    logic        hit;
    logic [7:0]  acc_n;
    logic        ex_n;

    assign cand  = acc_q | (8'd1 << k_q);
    assign hit   = (res_q <= y_q);
    assign acc_n = hit ? cand : acc_q;
    assign ex_n  = hit ? (res_q == y_q) : ex_r_q;

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        b_d        = b_q;
        acc_d      = acc_q;
        k_d        = k_q;
        ex_r_d     = ex_r_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        a_d        = a_q;
        exact_d    = exact_q;
        err_d      = err_q;
        fn_start_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    y_d     = y_bi;
                    b_d     = b_bi;
                    acc_d   = 8'd0;
                    k_d     = 3'd7;
                    ex_r_d  = (y_bi == 24'd0);
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A unit still busy from an abandoned run must drain first.
                if (!fn_busy_i) begin
                    fn_start_o = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (fn_busy_i) begin
                    state_d = WAIT_LO;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'd8) begin
                        err_d   = 1'b1;
                        a_d     = 8'd0;
                        exact_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!fn_busy_i) begin
                    res_d   = fn_result_bi;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_d  = acc_n;
                ex_r_d = ex_n;
                if (k_q == 3'd0) begin
                    a_d     = acc_n;
                    exact_d = ex_n;
                    state_d = IDLE;
                end else begin
                    k_d     = k_q - 3'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            y_q     <= 24'd0;
            b_q     <= 8'd0;
            acc_q   <= 8'd0;
            k_q     <= 3'd0;
            ex_r_q  <= 1'b0;
            cnt_q   <= 4'd0;
            res_q   <= 24'd0;
            a_q     <= 8'd0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            ex_r_q  <= ex_r_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            a_q     <= a_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign a_bo    = a_q;
    assign exact_o = exact_q;
    assign err_o   = err_q;
    assign fn_a_bo = (state_q == IDLE) ? 8'd0 : cand;
    assign fn_b_bo = (state_q == IDLE) ? 8'd0 : b_q;

endmodule

// File: tb/tb_func_inverse.sv
// Bench for func_inverse: behavioural function-unit model, vector table,
// randomized solves against a brute-force max-a search, timeout and reset cases.
module tb_func_inverse;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [23:0] y_bi;
    logic [7:0]  b_bi;
    logic        busy_o;
    logic [7:0]  a_bo;
    logic        exact_o;
    logic        err_o;
    logic [7:0]  fn_a_bo;
    logic [7:0]  fn_b_bo;
    logic        fn_start_o;
    logic        fu_busy = 1'b0;
    logic [23:0] fu_res = 24'd0;

    func_inverse dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .y_bi        (y_bi),
        .b_bi        (b_bi),
        .busy_o      (busy_o),
        .a_bo        (a_bo),
        .exact_o     (exact_o),
        .err_o       (err_o),
        .fn_a_bo     (fn_a_bo),
        .fn_b_bo     (fn_b_bo),
        .fn_start_o  (fn_start_o),
        .fn_busy_i   (fu_busy),
        .fn_result_bi(fu_res)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] fcalc(input logic [7:0] a, input logic [7:0] b);
        longint r;
        r = longint'(a) * longint'(a) * longint'(a) + longint'(a) * longint'(b);
        return r[23:0];
    endfunction

    // Function-unit model: busy for L cycles after a sampled start, garbage result meanwhile.
    bit         dead = 1'b0;
    bit         lat_rand = 1'b0;
    int         lat_fix = 3;
    int         fu_cnt = 0;
    logic [7:0] cap_a = 8'd0;
    logic [7:0] cap_b = 8'd0;

    always @(posedge clk) begin
        if (fu_busy) begin
            if (fu_cnt <= 1) begin
                fu_busy <= 1'b0;
                fu_res  <= fcalc(cap_a, cap_b);
            end else begin
                fu_cnt <= fu_cnt - 1;
            end
        end else if (fn_start_o && !dead) begin
            fu_busy <= 1'b1;
            fu_cnt  <= lat_rand ? int'($urandom_range(20, 1)) : lat_fix;
            cap_a   <= fn_a_bo;
            cap_b   <= fn_b_bo;
            fu_res  <= 24'($urandom);
        end
    end

    // Protocol monitors
    bit stab_on = 1'b0;
    int stab_bad = 0;
    int bad_start = 0;
    int pulses = 0;
    int st_w = 0;
    int max_w = 0;

    always @(negedge clk) begin
        if (stab_on && fu_busy && (fn_a_bo !== cap_a || fn_b_bo !== cap_b))
            stab_bad++;
        if (fn_start_o && fu_busy)
            bad_start++;
        if (fn_start_o) begin
            pulses++;
            st_w++;
        end else begin
            if (st_w > max_w) max_w = st_w;
            st_w = 0;
        end
    end

    task automatic ref_solve(input logic [23:0] y, input logic [7:0] b,
                             output logic [7:0] a, output logic ex);
        a  = 8'd0;
        ex = 1'b0;
        for (int c = 255; c >= 0; c--) begin
            if (longint'(c) * c * c + longint'(c) * b <= longint'(y)) begin
                a  = 8'(c);
                ex = (longint'(c) * c * c + longint'(c) * b == longint'(y));
                break;
            end
        end
    endtask

    task automatic start_run(input logic [23:0] y, input logic [7:0] b);
        @(negedge clk);
        start_i = 1'b1;
        y_bi    = y;
        b_bi    = b;
        @(negedge clk);
        start_i = 1'b0;
        y_bi    = 24'($urandom);
        b_bi    = 8'($urandom);
    endtask

    task automatic wait_done(input bit noise, output int cyc);
        cyc = 0;
        while (busy_o && cyc < 3000) begin
            if (noise) begin
                start_i = 1'($urandom_range(1, 0));
                y_bi    = 24'($urandom);
                b_bi    = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("done_in_time", 32'(cyc < 3000), 32'd1);
    endtask

    typedef struct {
        logic [23:0] y;
        logic [7:0]  b;
        logic [7:0]  a;
        logic        ex;
    } vec_t;

    vec_t vt[6];

    initial begin
        int         cyc;
        logic [7:0] ea;
        logic       ee;
        logic [23:0] yy;
        logic [7:0] bb;
        logic [7:0] a0;

        vt[0] = '{y: 24'd33,       b: 8'd2,   a: 8'd3,   ex: 1'b1};
        vt[1] = '{y: 24'd34,       b: 8'd2,   a: 8'd3,   ex: 1'b0};
        vt[2] = '{y: 24'd32,       b: 8'd2,   a: 8'd2,   ex: 1'b0};
        vt[3] = '{y: 24'd16646400, b: 8'd255, a: 8'd255, ex: 1'b1};
        vt[4] = '{y: 24'hFFFFFF,   b: 8'd0,   a: 8'd255, ex: 1'b0};
        vt[5] = '{y: 24'd7,        b: 8'd0,   a: 8'd1,   ex: 1'b0};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        y_bi    = 24'd0;
        b_bi    = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_a", 32'(a_bo), 32'd0);
        chk("rst_exact", 32'(exact_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_fn_start", 32'(fn_start_o), 32'd0);
        chk("rst_fn_a", 32'(fn_a_bo), 32'd0);
        chk("rst_fn_b", 32'(fn_b_bo), 32'd0);
        rst_ni = 1'b1;

        // y=0 with L=3: 48 busy cycles, 8 single-cycle start pulses
        pulses = 0;
        max_w  = 0;
        start_run(24'd0, 8'd0);
        wait_done(1'b0, cyc);
        chk("y0_busy_cycles", 32'(cyc), 32'd48);
        chk("y0_a", 32'(a_bo), 32'd0);
        chk("y0_exact", 32'(exact_o), 32'd1);
        chk("y0_err", 32'(err_o), 32'd0);
        chk("y0_pulses", 32'(pulses), 32'd8);
        chk("y0_pulse_width", 32'(max_w), 32'd1);

        for (int i = 0; i < 6; i++) begin
            start_run(vt[i].y, vt[i].b);
            wait_done(1'b0, cyc);
            chk($sformatf("vec%0d_a", i), 32'(a_bo), 32'(vt[i].a));
            chk($sformatf("vec%0d_exact", i), 32'(exact_o), 32'(vt[i].ex));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'd0);
        end

        // Dead unit: timeout after ISSUE + 8 WAIT_HI cycles
        dead = 1'b1;
        start_run(24'd500, 8'd4);
        wait_done(1'b0, cyc);
        chk("to_busy_cycles", 32'(cyc), 32'd9);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_a", 32'(a_bo), 32'd0);
        chk("to_exact", 32'(exact_o), 32'd0);
        dead = 1'b0;
        start_run(24'd500, 8'd4);
        wait_done(1'b0, cyc);
        chk("rec_err", 32'(err_o), 32'd0);
        chk("rec_a", 32'(a_bo), 32'd7);

        // Randomized solves with random latency and start noise
        lat_rand = 1'b1;
        stab_on  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bb = 8'($urandom);
            if (i % 2 == 1) begin
                a0 = 8'($urandom);
                yy = fcalc(a0, bb) + 24'($urandom_range(2, 0)) - 24'd1;
            end else begin
                yy = 24'($urandom);
            end
            ref_solve(yy, bb, ea, ee);
            start_run(yy, bb);
            wait_done(1'b1, cyc);
            chk($sformatf("rnd%0d_a y=%0d b=%0d", i, yy, bb), 32'(a_bo), 32'(ea));
            chk($sformatf("rnd%0d_exact", i), 32'(exact_o), 32'(ee));
        end
        stab_on  = 1'b0;
        lat_rand = 1'b0;
        chk("operand_stability", 32'(stab_bad), 32'd0);

        // Reset while the unit is busy, then restart behind the draining unit
        lat_fix = 15;
        start_run(24'd5000, 8'd3);
        cyc = 0;
        while (!fu_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_unit_busy", 32'(fu_busy), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_a", 32'(a_bo), 32'd0);
        chk("mid_rst_exact", 32'(exact_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_fn_start", 32'(fn_start_o), 32'd0);
        chk("mid_rst_fn_a", 32'(fn_a_bo), 32'd0);
        chk("mid_rst_fn_b", 32'(fn_b_bo), 32'd0);
        rst_ni = 1'b1;
        start_run(24'd1000, 8'd10);
        chk("stall_unit_busy", 32'(fu_busy), 32'd1);
        chk("stall_fn_start", 32'(fn_start_o), 32'd0);
        wait_done(1'b0, cyc);
        chk("post_rst_a", 32'(a_bo), 32'd9);
        chk("post_rst_exact", 32'(exact_o), 32'd0);
        chk("post_rst_err", 32'(err_o), 32'd0);
        chk("no_start_while_busy", 32'(bad_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
